// File: rtl/alu_wide_serial.sv
// rtl/alu_wide_serial.sv - byte-serial width-parametrised ALU with start/busy/done handshake (optional macro: ALU_WIDE_BCD_EN)
module alu_wide_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RDY,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             right,
    input  logic             arith,
    input  logic [WIDTH-1:0] AI,
    input  logic [WIDTH-1:0] BI,
    input  logic             CI,
    input  logic             BCD,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] OUT,
    output logic             CO,
    output logic             V,
    output logic             N,
    output logic             Z,
    output logic             HC
);

    localparam int         NB       = WIDTH / 8;
    localparam logic [2:0] LAST_IDX = 3'(NB - 1);

    typedef logic [WIDTH-1:0] word_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    word_t      ai_q, ai_d;
    word_t      bi_q, bi_d;
    word_t      acc_q, acc_d;
    word_t      out_q, out_d;
    logic [3:0] op_q, op_d;
    logic       right_q, right_d;
    logic       arith_q, arith_d;
    logic       ci_q, ci_d;
    logic       carry_q, carry_d;
    logic       v_hold_q, v_hold_d;
    logic       hc_hold_q, hc_hold_d;
    logic       co_q, co_d;
    logic       v_q, v_d;
    logic       n_q, n_d;
    logic       z_q, z_d;
    logic       hc_q, hc_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

`ifdef ALU_WIDE_BCD_EN
    logic       bcd_q, bcd_d;
`else
    logic       bcd_unused;
    assign bcd_unused = BCD;
`endif

    // Per-byte datapath signals for the byte selected by idx_q
    logic [5:0] base;
    logic       fill;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [7:0] logic_byte;
    logic [7:0] adder_b;
    logic [7:0] sum_byte;
    logic [4:0] lo_sum;
    logic [4:0] hi_sum;
    logic [3:0] lo_nib;
    logic [3:0] hi_nib;
    logic       lo_carry;
    logic       hi_carry;
    logic       bcd_mode;
    logic       v_cur;
    logic       last_byte;

    // One byte of the 8-bit ALU: logic select, adder operand select, nibble adder with optional decimal adjust
    always_comb begin
        base       = {idx_q, 3'b000};
        fill       = arith_q ? ai_q[WIDTH-1] : ci_q;
        a_byte     = 8'(ai_q >> base);
        b_byte     = 8'(bi_q >> base);
`ifdef ALU_WIDE_BCD_EN
        bcd_mode   = bcd_q && (op_q == 4'b0011) && !right_q;
`else
        bcd_mode   = 1'b0;
`endif
        if (right_q) begin
            // Shifted byte: bit 7 comes from bit 0 of the byte above, or the fill bit for the MSB byte
            logic_byte = 8'(({fill, ai_q} >> base) >> 1);
        end else begin
            case (op_q[1:0])
                2'b00:   logic_byte = a_byte | b_byte;
                2'b01:   logic_byte = a_byte & b_byte;
                2'b10:   logic_byte = a_byte ^ b_byte;
                default: logic_byte = a_byte;
            endcase
        end
        case (op_q[3:2])
            2'b00:   adder_b = b_byte;
            2'b01:   adder_b = ~b_byte;
            2'b10:   adder_b = logic_byte;
            default: adder_b = 8'h00;
        endcase
        lo_sum = {1'b0, logic_byte[3:0]} + {1'b0, adder_b[3:0]} + {4'b0000, carry_q};
        lo_nib   = lo_sum[3:0];
        lo_carry = lo_sum[4];
`ifdef ALU_WIDE_BCD_EN
        if (bcd_mode && (lo_sum >= 5'd10)) begin
            lo_nib   = lo_sum[3:0] + 4'd6;
            lo_carry = 1'b1;
        end
`endif
        hi_sum = {1'b0, logic_byte[7:4]} + {1'b0, adder_b[7:4]} + {4'b0000, lo_carry};
        hi_nib   = hi_sum[3:0];
        hi_carry = hi_sum[4];
`ifdef ALU_WIDE_BCD_EN
        if (bcd_mode && (hi_sum >= 5'd10)) begin
            hi_nib   = hi_sum[3:0] + 4'd6;
            hi_carry = 1'b1;
        end
`endif
        sum_byte  = {hi_nib, lo_nib};
        v_cur     = a_byte[7] ^ adder_b[7] ^ hi_carry ^ sum_byte[7];
        last_byte = right_q ? (idx_q == 3'd0) : (idx_q == LAST_IDX);
    end

    // Sequencer next state: latch operands on start, walk the bytes, publish result and flags on completion
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ai_d      = ai_q;
        bi_d      = bi_q;
        acc_d     = acc_q;
        out_d     = out_q;
        op_d      = op_q;
        right_d   = right_q;
        arith_d   = arith_q;
        ci_d      = ci_q;
        carry_d   = carry_q;
        v_hold_d  = v_hold_q;
        hc_hold_d = hc_hold_q;
        co_d      = co_q;
        v_d       = v_q;
        n_d       = n_q;
        z_d       = z_q;
        hc_d      = hc_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef ALU_WIDE_BCD_EN
        bcd_d     = bcd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ai_d    = AI;
                    bi_d    = BI;
                    op_d    = op;
                    right_d = right;
                    arith_d = arith;
                    ci_d    = CI;
`ifdef ALU_WIDE_BCD_EN
                    bcd_d   = BCD;
`endif
                    // Shifts never chain through the adder; op[3:2]=11 also ignores the carry in
                    carry_d = (right || (op[3:2] == 2'b11)) ? 1'b0 : CI;
                    idx_d   = right ? LAST_IDX : 3'd0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = (acc_q & ~(word_t'(8'hFF) << base)) | (word_t'(sum_byte) << base);
                carry_d = right_q ? 1'b0 : hi_carry;
                if (idx_q == LAST_IDX) begin
                    v_hold_d  = v_cur;
                    hc_hold_d = lo_carry;
                end
                if (last_byte) begin
                    out_d   = acc_d;
                    co_d    = right_q ? ai_q[0] : hi_carry;
                    n_d     = acc_d[WIDTH-1];
                    z_d     = (acc_d == '0);
                    v_d     = (idx_q == LAST_IDX) ? v_cur : v_hold_q;
                    hc_d    = (idx_q == LAST_IDX) ? lo_carry : hc_hold_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = right_q ? (idx_q - 3'd1) : (idx_q + 3'd1);
                end
            end
            default: begin
                done_d  = 1'b0;
                idx_d   = 3'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; RDY low freezes everything, reset abandons any operation in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            ai_q      <= '0;
            bi_q      <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            op_q      <= 4'd0;
            right_q   <= 1'b0;
            arith_q   <= 1'b0;
            ci_q      <= 1'b0;
            carry_q   <= 1'b0;
            v_hold_q  <= 1'b0;
            hc_hold_q <= 1'b0;
            co_q      <= 1'b0;
            v_q       <= 1'b0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            hc_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ALU_WIDE_BCD_EN
            bcd_q     <= 1'b0;
`endif
        end else if (RDY) begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ai_q      <= ai_d;
            bi_q      <= bi_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            op_q      <= op_d;
            right_q   <= right_d;
            arith_q   <= arith_d;
            ci_q      <= ci_d;
            carry_q   <= carry_d;
            v_hold_q  <= v_hold_d;
            hc_hold_q <= hc_hold_d;
            co_q      <= co_d;
            v_q       <= v_d;
            n_q       <= n_d;
            z_q       <= z_d;
            hc_q      <= hc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef ALU_WIDE_BCD_EN
            bcd_q     <= bcd_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign OUT  = out_q;
    assign CO   = co_q;
    assign V    = v_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign HC   = hc_q;

endmodule

// File: tb/tb_alu_wide_serial.sv
// tb/tb_alu_wide_serial.sv - directed self-checking bench for alu_wide_serial (WIDTH=16)
module tb_alu_wide_serial;

    localparam int WIDTH = 16;
    localparam int NB    = WIDTH / 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             RDY;
    logic             start;
    logic [3:0]       op;
    logic             right;
    logic             arith;
    logic [WIDTH-1:0] AI;
    logic [WIDTH-1:0] BI;
    logic             CI;
    logic             BCD;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] OUT;
    logic             CO, V, N, Z, HC;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_wide_serial #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .RDY(RDY), .start(start), .op(op),
        .right(right), .arith(arith), .AI(AI), .BI(BI), .CI(CI), .BCD(BCD),
        .busy(busy), .done(done), .OUT(OUT), .CO(CO), .V(V), .N(N), .Z(Z), .HC(HC)
    );

    // Issue one operation, wait (bounded) for done, then let DONE return to IDLE
    task automatic run_op(input logic [3:0] o, input logic r, input logic ar,
                          input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic d, output int cyc, output logic busy_seen);
        @(negedge clk);
        op = o; right = r; arith = ar; AI = a; BI = b; CI = c; BCD = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_seen = busy;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (OUT !== 16'h0000) begin errors++; $display("FAIL reset_out got %h exp 0000", OUT); end
        checks++;
        if ({CO, V, N, Z, HC} !== 5'b00000) begin errors++; $display("FAIL reset_flags got %b exp 00000", {CO, V, N, Z, HC}); end
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_hs got %b exp 00", {busy, done}); end
    endtask

    task automatic test_add();
        int cyc;
        logic b1;
        run_op(4'b0011, 1'b0, 1'b0, 16'h12FF, 16'h0001, 1'b0, 1'b0, cyc, b1);
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL add_busy got %b exp 1", b1); end
        checks++;
        if (cyc !== NB) begin errors++; $display("FAIL add_latency got %0d exp %0d", cyc, NB); end
        checks++;
        if (OUT !== 16'h1300) begin errors++; $display("FAIL add_out got %h exp 1300", OUT); end
        checks++;
        if ({CO, V, N, Z, HC} !== 5'b00000) begin errors++; $display("FAIL add_flags got %b exp 00000", {CO, V, N, Z, HC}); end
        run_op(4'b0011, 1'b0, 1'b0, 16'h0F00, 16'h0100, 1'b0, 1'b0, cyc, b1);
        checks++;
        if ({OUT, CO, V, N, Z, HC} !== {16'h1000, 5'b00001}) begin errors++; $display("FAIL add_hc got %h/%b exp 1000/00001", OUT, {CO, V, N, Z, HC}); end
        run_op(4'b0011, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, cyc, b1);
        checks++;
        if ({OUT, CO, V, N, Z, HC} !== {16'h0000, 5'b10011}) begin errors++; $display("FAIL add_wrap got %h/%b exp 0000/10011", OUT, {CO, V, N, Z, HC}); end
        run_op(4'b1011, 1'b0, 1'b0, 16'h8081, 16'h0000, 1'b0, 1'b0, cyc, b1);
        checks++;
        if ({OUT, CO, V, N, Z, HC} !== {16'h0102, 5'b11000}) begin errors++; $display("FAIL asl_word got %h/%b exp 0102/11000", OUT, {CO, V, N, Z, HC}); end
    endtask

    task automatic test_sub();
        int cyc;
        logic b1;
        run_op(4'b0111, 1'b0, 1'b0, 16'h8000, 16'h0001, 1'b1, 1'b0, cyc, b1);
        checks++;
        if (OUT !== 16'h7FFF) begin errors++; $display("FAIL sub_out got %h exp 7fff", OUT); end
        checks++;
        if ({CO, V, N, Z, HC} !== 5'b11000) begin errors++; $display("FAIL sub_flags got %b exp 11000", {CO, V, N, Z, HC}); end
    endtask

    task automatic test_logic();
        int cyc;
        logic b1;
        run_op(4'b1101, 1'b0, 1'b0, 16'hF0F0, 16'h3C3C, 1'b1, 1'b0, cyc, b1);
        checks++;
        if ({OUT, CO, N, Z} !== {16'h3030, 3'b000}) begin errors++; $display("FAIL and_res got %h/%b exp 3030/000", OUT, {CO, N, Z}); end
        run_op(4'b1110, 1'b0, 1'b0, 16'hFFFF, 16'h00FF, 1'b0, 1'b0, cyc, b1);
        checks++;
        if ({OUT, CO, N, Z} !== {16'hFF00, 3'b010}) begin errors++; $display("FAIL eor_res got %h/%b exp ff00/010", OUT, {CO, N, Z}); end
    endtask

    task automatic test_shift();
        int cyc;
        logic b1;
        run_op(4'b1111, 1'b1, 1'b0, 16'h0181, 16'h0000, 1'b1, 1'b0, cyc, b1);
        checks++;
        if ({OUT, CO, N, Z} !== {16'h80C0, 3'b110}) begin errors++; $display("FAIL ror_res got %h/%b exp 80c0/110", OUT, {CO, N, Z}); end
        checks++;
        if (cyc !== NB) begin errors++; $display("FAIL ror_latency got %0d exp %0d", cyc, NB); end
        run_op(4'b1111, 1'b1, 1'b1, 16'h8002, 16'h0000, 1'b0, 1'b0, cyc, b1);
        checks++;
        if ({OUT, CO, N, Z} !== {16'hC001, 3'b010}) begin errors++; $display("FAIL asr_res got %h/%b exp c001/010", OUT, {CO, N, Z}); end
    endtask

    task automatic test_bcd();
        int cyc;
        logic b1;
        logic [15:0] exp_out;
        logic [1:0]  exp_fl;
        run_op(4'b0011, 1'b0, 1'b0, 16'h0999, 16'h0001, 1'b0, 1'b1, cyc, b1);
`ifdef ALU_WIDE_BCD_EN
        exp_out = 16'h1000; exp_fl = 2'b01;
`else
        exp_out = 16'h099A; exp_fl = 2'b00;
`endif
        checks++;
        if ({OUT, CO, HC} !== {exp_out, exp_fl}) begin errors++; $display("FAIL bcd_add got %h/%b exp %h/%b", OUT, {CO, HC}, exp_out, exp_fl); end
        run_op(4'b0011, 1'b0, 1'b0, 16'h9999, 16'h0001, 1'b0, 1'b1, cyc, b1);
`ifdef ALU_WIDE_BCD_EN
        exp_out = 16'h0000; exp_fl = 2'b11;
`else
        exp_out = 16'h999A; exp_fl = 2'b00;
`endif
        checks++;
        if ({OUT, CO, Z} !== {exp_out, exp_fl}) begin errors++; $display("FAIL bcd_wrap got %h/%b exp %h/%b", OUT, {CO, Z}, exp_out, exp_fl); end
        run_op(4'b0111, 1'b0, 1'b0, 16'h1000, 16'h0001, 1'b1, 1'b1, cyc, b1);
        checks++;
        if ({OUT, CO} !== {16'h0FFF, 1'b1}) begin errors++; $display("FAIL bcd_ignored_sub got %h/%b exp 0fff/1", OUT, CO); end
    endtask

    task automatic test_stall();
        int   cyc;
        logic busy_ok;
        logic busy_late;
        @(negedge clk);
        op = 4'b0011; right = 1'b0; arith = 1'b0; AI = 16'h12FF; BI = 16'h0001; CI = 1'b0; BCD = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc < NB + 3 && busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == 1) begin RDY = 1'b0; start = 1'b1; AI = 16'h5555; end
            if (cyc == 4) RDY = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (cyc !== NB + 3) begin errors++; $display("FAIL stall_latency got %0d exp %0d", cyc, NB + 3); end
        checks++;
        if (busy_ok !== 1'b1) begin errors++; $display("FAIL stall_busy got %b exp 1", busy_ok); end
        checks++;
        if ({OUT, CO, Z} !== {16'h1300, 2'b00}) begin errors++; $display("FAIL stall_out got %h/%b exp 1300/00", OUT, {CO, Z}); end
        RDY = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("FAIL done_hold got %b exp 10", {done, busy}); end
        RDY = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_clear got %b exp 0", done); end
        busy_late = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_late = 1'b1;
        end
        checks++;
        if (busy_late !== 1'b0) begin errors++; $display("FAIL no_queued_op got %b exp 0", busy_late); end
    endtask

    task automatic test_reset_mid_run();
        int   cyc;
        logic b1;
        @(negedge clk);
        op = 4'b0111; right = 1'b0; AI = 16'h8000; BI = 16'h0001; CI = 1'b1; BCD = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_mid_hs got %b exp 00", {busy, done}); end
        checks++;
        if ({OUT, CO, V, N, Z, HC} !== {16'h0000, 5'b00000}) begin errors++; $display("FAIL rst_mid_out got %h/%b exp 0000/00000", OUT, {CO, V, N, Z, HC}); end
        @(negedge clk);
        reset_n = 1'b1;
        run_op(4'b1100, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, cyc, b1);
        checks++;
        if ({OUT, CO, N, Z} !== {16'h0000, 3'b001}) begin errors++; $display("FAIL post_rst_or got %h/%b exp 0000/001", OUT, {CO, N, Z}); end
        checks++;
        if (cyc !== NB) begin errors++; $display("FAIL post_rst_latency got %0d exp %0d", cyc, NB); end
    endtask

    initial begin
        reset_n = 1'b0; RDY = 1'b1; start = 1'b0; op = 4'd0; right = 1'b0; arith = 1'b0;
        AI = '0; BI = '0; CI = 1'b0; BCD = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_bcd();
        test_stall();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
